me_sad_min_select: RTL
======================

# me_sad_min_select

Downstream of the PE array controller and PE array. Consumes the four 16x16 sub-block SADs the PE array produces for each search candidate, and derives the merged SADs for the 16x32, 32x16 and 32x32 partitions. Keeps the minimum SAD and its motion vector for all 9 partitions over the full search window. When the window completes, it streams the 9 results to the mode-decision stage with a valid/ready handshake.

## Interface
Parameters:
- SAD_W, 16, width of one 16x16 sub-block SAD
- SRCH_R, 32, search range; candidates cover MV -SRCH_R..SRCH_R-1 in x and y (64x64 = 4096 at default)
- MV_W, 7, signed MV component width; must hold -SRCH_R..SRCH_R-1

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  pulse: begin a new search window; sampled in IDLE only
- sad_valid  in  1  sub-block SADs valid for the next candidate (raster order: x fastest)
- sad_cb0..sad_cb3  in  SAD_W each  SADs of sub-blocks TL, TR, BL, BR
- busy  out  1  high from accepted start until last result handshake
- out_valid  out  1  result word valid
- out_ready  in  1  consumer accepts result
- out_part  out  4  partition index 0..8
- out_sad  out  SAD_W+2  best SAD, zero-extended
- out_mv_x, out_mv_y  out  MV_W each  signed best MV

## Operation
- Partition indices:
  - 0-3: sub-blocks TL, TR, BL, BR
  - 4: top 32x16 (cb0+cb1); 5: bottom 32x16 (cb2+cb3)
  - 6: left 16x32 (cb0+cb2); 7: right 16x32 (cb1+cb3)
  - 8: 32x32 (sum of all four)
- Arithmetic widths: pair sums SAD_W+1 bits, quad sum SAD_W+2 bits; no saturation needed.
- States: IDLE, SEARCH, FLUSH, DRAIN.
- IDLE:
  - start=1 → SEARCH; clear counters; set all 9 best SADs to all-ones; set best MVs to 0.
  - sad_valid is ignored.
- SEARCH:
  - Each sad_valid cycle accepts one candidate with col/row counters 0..2*SRCH_R-1.
  - MV of the candidate = (col-SRCH_R, row-SRCH_R).
  - col wraps to 0 and row increments on col == 2*SRCH_R-1.
  - Accepting the 4096th candidate → FLUSH.
  - sad_valid low: counters hold (gaps allowed).
- Pipeline:
  - Stage 1 registers the candidate SADs, their sums and the MV.
  - Stage 2 compares each partition and updates its best when the new SAD is strictly less than the stored best. Ties keep the earlier (raster-first) candidate.
- FLUSH: 2 cycles so the last candidate reaches stage 2, then DRAIN.
- DRAIN:
  - Present partitions 0..8 in order; advance on out_valid & out_ready.
  - Handshake on partition 8 → IDLE.
  - out_valid holds and data is stable while out_ready=0.
- start outside IDLE is ignored. sad_valid outside SEARCH is ignored, including any beat after the 4096th.

## Timing
- Reset values: busy=0, out_valid=0, out_part=0, out_sad=0, out_mv_x=0, out_mv_y=0, state IDLE, all counters 0.
- Cycle-level:
  - busy rises the cycle after start is sampled in IDLE.
  - out_valid rises 3 cycles after the clock edge that accepts the last candidate.
  - busy falls the cycle after the partition-8 handshake.
- Throughput: 1 candidate per clock; 9 result words back-to-back at best when out_ready=1.
- Reset mid-operation: immediate return to reset values; partial results are discarded.
- start in the same cycle the DRAIN exits: ignored; start must be re-sent once in IDLE.

## Structure
- Shared ME package:
  - partition index constants PART_TL..PART_32X32
  - SRCH_R default
  - MV struct typedef (signed x, y of MV_W)
- One sub-module, me_min_reg:
  - one partition's best SAD/MV register with strict-less compare, synchronous init and enable
  - instantiated 9 times
- FSM, candidate counters, adder stage and drain mux live in the top.

## Test plan
- Constant SADs: all candidates cb0..cb3=100 → every partition reports MV (-32,-32); SADs 100 (parts 0-3), 200 (parts 4-7), 400 (part 8).
- Unique minimum: cb2=5 at candidate col 40, row 10, all else 1000 → part 2 MV (8,-22) SAD 5. Parts 5 and 6 report the same MV with SAD 1005. Part 8 reports the same MV with SAD 3005.
- Tie: equal minimum 7 on cb0 at candidates 100 and 3000 → part 0 reports candidate 100's MV.
- Backpressure and gaps: random sad_valid gaps; out_ready low for 5 cycles at part 3 → results unchanged, no word lost or duplicated, exactly 9 handshakes.
- Max values: all SADs 65535 → part 8 SAD 262140 without overflow.
- Reset and ignored events: rst_n low mid-SEARCH → outputs at reset values; a new start then runs cleanly. start during DRAIN is ignored, and extra sad_valid beats after the 4096th do not alter results.

Source files
------------

// File: rtl/me_sad_min_select_pkg.sv
// me_sad_min_select_pkg: shared ME constants, partition indices and MV type
// Contents: default SAD/MV widths, default search range, partition index
// constants PART_TL..PART_32X32, packed signed MV struct.
package me_sad_min_select_pkg;

    localparam int ME_SAD_W  = 16;
    localparam int ME_SRCH_R = 32;
    localparam int ME_MV_W   = 7;

    localparam logic [3:0] PART_TL    = 4'd0;
    localparam logic [3:0] PART_TR    = 4'd1;
    localparam logic [3:0] PART_BL    = 4'd2;
    localparam logic [3:0] PART_BR    = 4'd3;
    localparam logic [3:0] PART_TOP   = 4'd4;
    localparam logic [3:0] PART_BOT   = 4'd5;
    localparam logic [3:0] PART_LEFT  = 4'd6;
    localparam logic [3:0] PART_RIGHT = 4'd7;
    localparam logic [3:0] PART_32X32 = 4'd8;

    typedef struct packed {
        logic signed [ME_MV_W-1:0] x;
        logic signed [ME_MV_W-1:0] y;
    } me_mv_t;

endpackage

// File: rtl/me_sad_min_select_if.sv
// me_sad_min_select_if: result stream from the SAD min-select to mode decision
// Signals: valid/ready handshake, part (partition 0..8), sad (best SAD,
// SAD_W+2 bits), mv_x/mv_y (signed best MV). master drives the result.
interface me_sad_min_select_if
    import me_sad_min_select_pkg::*;
#(
    parameter int SAD_W = ME_SAD_W,
    parameter int MV_W  = ME_MV_W
) ();

    logic                    valid;
    logic                    ready;
    logic [3:0]              part;
    logic [SAD_W+1:0]        sad;
    logic signed [MV_W-1:0]  mv_x;
    logic signed [MV_W-1:0]  mv_y;

    modport master (output valid, part, sad, mv_x, mv_y, input ready);
    modport slave  (input valid, part, sad, mv_x, mv_y, output ready);

endinterface

// File: rtl/me_sad_min_select_min_reg.sv
// me_min_reg: best SAD/MV register for one partition with strict-less update
// Ports: clk, rst_n (async, active-low), init_i (sync reload to worst),
// en_i (candidate valid), sad_i/mv_x_i/mv_y_i (candidate), best_*_o (stored best).
module me_min_reg #(
    parameter int W    = 18,
    parameter int MV_W = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   init_i,
    input  logic                   en_i,
    input  logic [W-1:0]           sad_i,
    input  logic signed [MV_W-1:0] mv_x_i,
    input  logic signed [MV_W-1:0] mv_y_i,
    output logic [W-1:0]           best_sad_o,
    output logic signed [MV_W-1:0] best_mv_x_o,
    output logic signed [MV_W-1:0] best_mv_y_o
);

    logic [W-1:0]           sad_q;
    logic signed [MV_W-1:0] mv_x_q, mv_y_q;

    // Strict less-than keeps the raster-first candidate on ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sad_q  <= '1;
            mv_x_q <= '0;
            mv_y_q <= '0;
        end else if (init_i) begin
            sad_q  <= '1;
            mv_x_q <= '0;
            mv_y_q <= '0;
        end else if (en_i && sad_i < sad_q) begin
            sad_q  <= sad_i;
            mv_x_q <= mv_x_i;
            mv_y_q <= mv_y_i;
        end
    end

    assign best_sad_o  = sad_q;
    assign best_mv_x_o = mv_x_q;
    assign best_mv_y_o = mv_y_q;

endmodule

// File: rtl/me_sad_min_select.sv
// me_sad_min_select: merges 16x16 SADs into 9 partitions, tracks per-partition minimum and streams results
// Ports: clk, rst_n (async, active-low), start_i (window start, IDLE only),
// sad_valid_i + sad_cb0_i..sad_cb3_i (TL/TR/BL/BR SADs, raster order),
// busy_o (window in progress), res (result stream master).
module me_sad_min_select
    import me_sad_min_select_pkg::*;
#(
    parameter int SAD_W  = ME_SAD_W,
    parameter int SRCH_R = ME_SRCH_R,
    parameter int MV_W   = ME_MV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             sad_valid_i,
    input  logic [SAD_W-1:0] sad_cb0_i,
    input  logic [SAD_W-1:0] sad_cb1_i,
    input  logic [SAD_W-1:0] sad_cb2_i,
    input  logic [SAD_W-1:0] sad_cb3_i,
    output logic             busy_o,
    me_sad_min_select_if.master res
);

    localparam int              BW   = SAD_W + 2;
    localparam int              CW   = $clog2(2 * SRCH_R);
    localparam logic [CW-1:0]   CMAX = CW'(2 * SRCH_R - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEARCH = 2'd1;
    localparam logic [1:0] FLUSH  = 2'd2;
    localparam logic [1:0] DRAIN  = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [CW-1:0]          col_q, row_q;
    logic                   flush_q;
    logic                   accept, last, init, hs, load;
    logic [3:0]             sel;
    logic [BW-1:0]          cand[9];

    logic                   s1_valid_q;
    logic [BW-1:0]          s1_sad_q[9];
    logic signed [MV_W-1:0] s1_mv_x_q, s1_mv_y_q;

    logic [BW-1:0]          best_sad[9];
    logic signed [MV_W-1:0] best_mv_x[9], best_mv_y[9];

    logic                   out_valid_q;
    logic [3:0]             out_part_q;
    logic [BW-1:0]          out_sad_q;
    logic signed [MV_W-1:0] out_mv_x_q, out_mv_y_q;

    always_comb begin
        accept = state_q == SEARCH && sad_valid_i;
        last   = accept && col_q == CMAX && row_q == CMAX;
        init   = state_q == IDLE && start_i;
        hs     = out_valid_q && res.ready;
        // Reload the output word on DRAIN entry and on every non-final handshake.
        load   = state_q == DRAIN && (!out_valid_q || (hs && out_part_q != PART_32X32));
        sel    = (out_valid_q && out_part_q != PART_32X32) ? out_part_q + 4'd1 : PART_TL;
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start_i ? SEARCH : IDLE;
            SEARCH:  state_d = last ? FLUSH : SEARCH;
            FLUSH:   state_d = flush_q ? DRAIN : FLUSH;
            default: state_d = (hs && out_part_q == PART_32X32) ? IDLE : DRAIN;
        endcase
        cand[PART_TL]    = BW'(sad_cb0_i);
        cand[PART_TR]    = BW'(sad_cb1_i);
        cand[PART_BL]    = BW'(sad_cb2_i);
        cand[PART_BR]    = BW'(sad_cb3_i);
        cand[PART_TOP]   = BW'(sad_cb0_i) + BW'(sad_cb1_i);
        cand[PART_BOT]   = BW'(sad_cb2_i) + BW'(sad_cb3_i);
        cand[PART_LEFT]  = BW'(sad_cb0_i) + BW'(sad_cb2_i);
        cand[PART_RIGHT] = BW'(sad_cb1_i) + BW'(sad_cb3_i);
        cand[PART_32X32] = BW'(sad_cb0_i) + BW'(sad_cb1_i) + BW'(sad_cb2_i) + BW'(sad_cb3_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            flush_q     <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_sad_q    <= '{default: '0};
            s1_mv_x_q   <= '0;
            s1_mv_y_q   <= '0;
            out_valid_q <= 1'b0;
            out_part_q  <= '0;
            out_sad_q   <= '0;
            out_mv_x_q  <= '0;
            out_mv_y_q  <= '0;
        end else begin
            state_q    <= state_d;
            flush_q    <= state_q == FLUSH && !flush_q;
            s1_valid_q <= accept;
            if (init) begin
                col_q <= '0;
                row_q <= '0;
            end else if (accept) begin
                col_q <= col_q == CMAX ? '0 : col_q + 1'b1;
                row_q <= col_q == CMAX ? row_q + 1'b1 : row_q;
            end
            if (accept) begin
                s1_sad_q  <= cand;
                s1_mv_x_q <= $signed(MV_W'(col_q) - MV_W'(SRCH_R));
                s1_mv_y_q <= $signed(MV_W'(row_q) - MV_W'(SRCH_R));
            end
            if (load) begin
                out_valid_q <= 1'b1;
                out_part_q  <= sel;
                out_sad_q   <= best_sad[sel];
                out_mv_x_q  <= best_mv_x[sel];
                out_mv_y_q  <= best_mv_y[sel];
            end else if (hs) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < 9; i++) begin : g_min
        me_min_reg #(.W(BW), .MV_W(MV_W)) u_min (
            .clk         (clk),
            .rst_n       (rst_n),
            .init_i      (init),
            .en_i        (s1_valid_q),
            .sad_i       (s1_sad_q[i]),
            .mv_x_i      (s1_mv_x_q),
            .mv_y_i      (s1_mv_y_q),
            .best_sad_o  (best_sad[i]),
            .best_mv_x_o (best_mv_x[i]),
            .best_mv_y_o (best_mv_y[i])
        );
    end

    assign busy_o    = state_q != IDLE;
    assign res.valid = out_valid_q;
    assign res.part  = out_part_q;
    assign res.sad   = out_sad_q;
    assign res.mv_x  = out_mv_x_q;
    assign res.mv_y  = out_mv_y_q;

endmodule
